execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_if.sv | 46 ++++
 rtl/execute_stage.sv | 193 +++++++++++++++++++
 tb/tb_execute_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Operand/control bundle from decode into the execute stage and its registered results toward memory.
// Master drives instruction fields; slave (execute_stage) returns results, address and flags.
interface execute_stage_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
);
    logic              valid_in;
    logic              stall;
    logic              flush;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] immediate;
    logic              use_imm;
    logic              mem_read_in;
    logic              mem_write_in;
    logic              mem_push_in;
    logic              mem_pop_in;
    logic              reg_write_in;
    logic [RD_W-1:0]   rd_in;

    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              memory_read;
    logic              memory_write;
    logic              memory_push;
    logic              memory_pop;
    logic              reg_write;
    logic [RD_W-1:0]   rd_out;
    logic [2:0]        ccr;

    modport master (
        output valid_in, stall, flush, alu_op, operand_a, operand_b, immediate, use_imm,
               mem_read_in, mem_write_in, mem_push_in, mem_pop_in, reg_write_in, rd_in,
        input  alu_result, address, write_data, memory_read, memory_write, memory_push,
               memory_pop, reg_write, rd_out, ccr
    );

    modport slave (
        input  valid_in, stall, flush, alu_op, operand_a, operand_b, immediate, use_imm,
               mem_read_in, mem_write_in, mem_push_in, mem_pop_in, reg_write_in, rd_in,
        output alu_result, address, write_data, memory_read, memory_write, memory_push,
               memory_pop, reg_write, rd_out, ccr
    );
endinterface

// File: rtl/execute_stage.sv
// Single-cycle ALU execute stage with {C,N,Z} condition register; results registered one cycle after accept.
// stall holds every output and ccr; flush or an idle slot registers a bubble; ccr only moves on accept.
module execute_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
) (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave bus
);

    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_LDM  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_INC  = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_SETC = 4'd12;
    localparam logic [3:0] OP_CLRC = 4'd13;

    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    localparam logic [DATA_W:0] ONE_W = {{DATA_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] wdata;
        logic              mem_read;
        logic              mem_write;
        logic              mem_push;
        logic              mem_pop;
        logic              reg_write;
        logic [RD_W-1:0]   rd;
    } ex_out_t;

    ex_out_t           out_q, out_d;
    logic [2:0]        ccr_q, ccr_d;

    logic              accept;
    logic              bubble;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] res;
    logic [DATA_W:0]   wide;
    logic [3:0]        shamt;
    logic              carry;
    logic              upd_c;
    logic              upd_zn;

    assign accept = bus.valid_in & ~bus.stall & ~bus.flush;
    assign bubble = bus.flush | (~bus.stall & ~bus.valid_in);

    // Arithmetic runs one bit wider so the carry/borrow falls out as bit DATA_W.
    always_comb begin
        a_val  = bus.operand_a;
        b_val  = bus.use_imm ? bus.immediate : bus.operand_b;
        shamt  = b_val[3:0];
        wide   = '0;
        res    = '0;
        carry  = 1'b0;
        upd_c  = 1'b0;
        upd_zn = 1'b0;
        case (bus.alu_op)
            OP_MOV: res = a_val;
            OP_LDM: res = bus.immediate;
            OP_ADD: begin
                wide   = {1'b0, a_val} + {1'b0, b_val};
                res    = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_SUB: begin
                wide   = {1'b0, a_val} - {1'b0, b_val};
                res    = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_AND: begin
                res    = a_val & b_val;
                upd_zn = 1'b1;
            end
            OP_OR: begin
                res    = a_val | b_val;
                upd_zn = 1'b1;
            end
            OP_NOT: begin
                res    = ~a_val;
                upd_zn = 1'b1;
            end
            OP_INC: begin
                wide   = {1'b0, a_val} + ONE_W;
                res    = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_DEC: begin
                wide   = {1'b0, a_val} - ONE_W;
                res    = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            // A zero shift passes A through and must not disturb C.
            OP_SHL: begin
                upd_zn = 1'b1;
                if (shamt == 4'd0) begin
                    res = a_val;
                end else begin
                    wide  = {1'b0, a_val} << shamt;
                    res   = wide[DATA_W-1:0];
                    carry = wide[DATA_W];
                    upd_c = 1'b1;
                end
            end
            OP_SHR: begin
                upd_zn = 1'b1;
                if (shamt == 4'd0) begin
                    res = a_val;
                end else begin
                    wide  = {a_val, 1'b0} >> shamt;
                    res   = wide[DATA_W:1];
                    carry = wide[0];
                    upd_c = 1'b1;
                end
            end
            OP_SETC: begin
                carry = 1'b1;
                upd_c = 1'b1;
            end
            OP_CLRC: begin
                carry = 1'b0;
                upd_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        out_d = out_q;
        ccr_d = ccr_q;
        if (bubble) begin
            out_d = '0;
        end else if (accept) begin
            out_d.result    = res;
            out_d.wdata     = a_val;
            out_d.mem_read  = bus.mem_read_in;
            out_d.mem_write = bus.mem_write_in;
            out_d.mem_push  = bus.mem_push_in;
            out_d.mem_pop   = bus.mem_pop_in;
            out_d.reg_write = bus.reg_write_in;
            out_d.rd        = bus.rd_in;
            if (upd_c) begin
                ccr_d[CCR_C] = carry;
            end
            if (upd_zn) begin
                ccr_d[CCR_N] = res[DATA_W-1];
                ccr_d[CCR_Z] = (res == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q <= '0;
            ccr_q <= '0;
        end else begin
            out_q <= out_d;
            ccr_q <= ccr_d;
        end
    end

    assign bus.alu_result   = out_q.result;
    assign bus.address      = out_q.result;
    assign bus.write_data   = out_q.wdata;
    assign bus.memory_read  = out_q.mem_read;
    assign bus.memory_write = out_q.mem_write;
    assign bus.memory_push  = out_q.mem_push;
    assign bus.memory_pop   = out_q.mem_pop;
    assign bus.reg_write    = out_q.reg_write;
    assign bus.rd_out       = out_q.rd;
    assign bus.ccr          = ccr_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed corner cases with literal expectations, then randomized traffic
// compared every cycle against an arithmetic reference model of the stage.
module tb_execute_stage;
    localparam int DW = 16;
    localparam int RW = 3;

    localparam logic [4:0] CTL_NONE = 5'b00000;
    localparam logic [4:0] CTL_WR   = 5'b01000;
    localparam logic [4:0] CTL_PUSH = 5'b00100;
    localparam logic [4:0] CTL_RW   = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_stage_if #(.DATA_W(DW), .RD_W(RW)) bus ();
    execute_stage #(.DATA_W(DW), .RD_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint m_alu, m_wd, m_rd;
    bit     m_mrd, m_mwr, m_push, m_pop, m_rw;
    bit     m_c, m_n, m_z;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_outputs();
        m_alu = 0; m_wd = 0; m_rd = 0;
        m_mrd = 0; m_mwr = 0; m_push = 0; m_pop = 0; m_rw = 0;
    endtask

    task automatic model_step();
        longint mask, a, b, r;
        int     n;
        bit     uz;
        mask = (64'd1 << DW) - 1;
        if (!reset) begin
            model_clear_outputs();
            m_c = 0; m_n = 0; m_z = 0;
        end else if (bus.flush || (!bus.stall && !bus.valid_in)) begin
            model_clear_outputs();
        end else if (!bus.stall) begin
            a  = longint'(bus.operand_a);
            b  = bus.use_imm ? longint'(bus.immediate) : longint'(bus.operand_b);
            n  = int'(b % 16);
            r  = 0;
            uz = 0;
            case (int'(bus.alu_op))
                1:  r = a;
                2:  r = longint'(bus.immediate);
                3:  begin r = (a + b) & mask; m_c = (a + b) > mask; uz = 1; end
                4:  begin r = (a - b) & mask; m_c = a < b; uz = 1; end
                5:  begin r = a & b; uz = 1; end
                6:  begin r = a | b; uz = 1; end
                7:  begin r = mask - a; uz = 1; end
                8:  begin r = (a + 1) & mask; m_c = (a == mask); uz = 1; end
                9:  begin r = (a - 1) & mask; m_c = (a == 0); uz = 1; end
                10: begin
                    uz = 1;
                    if (n == 0) r = a;
                    else begin r = (a * (64'd1 << n)) & mask; m_c = ((a >> (DW - n)) % 2) == 1; end
                end
                11: begin
                    uz = 1;
                    if (n == 0) r = a;
                    else begin r = a / (64'd1 << n); m_c = ((a >> (n - 1)) % 2) == 1; end
                end
                12: m_c = 1;
                13: m_c = 0;
                default: r = 0;
            endcase
            if (uz) begin
                m_z = (r == 0);
                m_n = r >= (64'd1 << (DW - 1));
            end
            m_alu = r;
            m_wd  = a;
            m_rd  = longint'(bus.rd_in);
            m_mrd = bus.mem_read_in; m_mwr = bus.mem_write_in;
            m_push = bus.mem_push_in; m_pop = bus.mem_pop_in; m_rw = bus.reg_write_in;
        end
    endtask

    task automatic compare_all();
        chk("alu_result",   bus.alu_result,   m_alu);
        chk("address",      bus.address,      m_alu);
        chk("write_data",   bus.write_data,   m_wd);
        chk("memory_read",  bus.memory_read,  m_mrd);
        chk("memory_write", bus.memory_write, m_mwr);
        chk("memory_push",  bus.memory_push,  m_push);
        chk("memory_pop",   bus.memory_pop,   m_pop);
        chk("reg_write",    bus.reg_write,    m_rw);
        chk("rd_out",       bus.rd_out,       m_rd);
        chk("ccr",          bus.ccr,          {m_c, m_n, m_z});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drv(input bit v, input bit s, input bit f, input logic [3:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                       input bit ui, input logic [4:0] ctl, input logic [RW-1:0] rdi);
        bus.valid_in  = v;
        bus.stall     = s;
        bus.flush     = f;
        bus.alu_op    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.immediate = imm;
        bus.use_imm   = ui;
        {bus.mem_read_in, bus.mem_write_in, bus.mem_push_in, bus.mem_pop_in, bus.reg_write_in} = ctl;
        bus.rd_in     = rdi;
    endtask

    function automatic logic [DW-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(DW-1){1'b0}}};
            3:       return {{(DW-1){1'b0}}, 1'b1};
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        m_c = 0; m_n = 0; m_z = 0;
        model_clear_outputs();

        // Reset, then load something nonzero so a later reset is observable
        reset = 1'b0;
        drv(0, 0, 0, 4'd0, '0, '0, '0, 0, CTL_NONE, '0);
        cycle();
        reset = 1'b1;
        drv(1, 0, 0, 4'd3, 16'h0001, 16'h0002, '0, 0, CTL_WR | CTL_RW, 3'd5);
        cycle();
        chk("lit_pre_reset_result", bus.alu_result, 16'h0003);

        // Reset while stalled clears everything
        reset = 1'b0;
        drv(1, 1, 0, 4'd3, 16'h0001, 16'h0002, '0, 0, CTL_WR, 3'd5);
        cycle();
        chk("lit_reset_result", bus.alu_result, 16'h0000);
        chk("lit_reset_ccr", bus.ccr, 3'b000);
        chk("lit_reset_memwr", bus.memory_write, 1'b0);
        reset = 1'b1;
        drv(1, 0, 0, 4'd3, 16'h0002, 16'h0003, '0, 0, CTL_RW, 3'd1);
        cycle();
        chk("lit_post_reset_accept", bus.alu_result, 16'h0005);

        // ADD carry out
        drv(1, 0, 0, 4'd3, 16'hFFFF, 16'h0001, '0, 0, CTL_RW, 3'd2);
        cycle();
        chk("lit_add_carry_result", bus.alu_result, 16'h0000);
        chk("lit_add_carry_ccr", bus.ccr, 3'b101);

        // SUB borrow via immediate, then AND keeps C
        drv(1, 0, 0, 4'd4, 16'h0003, 16'h0000, 16'h0005, 1, CTL_RW, 3'd3);
        cycle();
        chk("lit_sub_borrow_result", bus.alu_result, 16'hFFFE);
        chk("lit_sub_borrow_ccr", bus.ccr, 3'b110);
        drv(1, 0, 0, 4'd5, 16'h0003, 16'h0005, '0, 0, CTL_RW, 3'd3);
        cycle();
        chk("lit_and_result", bus.alu_result, 16'h0001);
        chk("lit_and_keeps_c", bus.ccr, 3'b100);

        // Store, stall twice, then stall+flush
        drv(1, 0, 0, 4'd3, 16'h0007, 16'h0010, '0, 0, CTL_WR, 3'd0);
        cycle();
        chk("lit_store_addr", bus.address, 16'h0017);
        chk("lit_store_wdata", bus.write_data, 16'h0007);
        chk("lit_store_memwr", bus.memory_write, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drv(1, 1, 0, 4'd8, 16'h1234, 16'h0000, '0, 0, CTL_RW, 3'd6);
            cycle();
            chk("lit_stall_addr", bus.address, 16'h0017);
            chk("lit_stall_memwr", bus.memory_write, 1'b1);
        end
        drv(1, 1, 1, 4'd8, 16'h1234, 16'h0000, '0, 0, CTL_RW, 3'd6);
        cycle();
        chk("lit_flush_memwr", bus.memory_write, 1'b0);
        chk("lit_flush_addr", bus.address, 16'h0000);
        chk("lit_flush_ccr", bus.ccr, 3'b000);

        // SETC then a push pass-through leaves flags alone
        drv(1, 0, 0, 4'd12, '0, '0, '0, 0, CTL_NONE, 3'd0);
        cycle();
        chk("lit_setc_ccr", bus.ccr, 3'b100);
        drv(1, 0, 0, 4'd1, 16'h00AB, 16'h0000, '0, 0, CTL_PUSH, 3'd0);
        cycle();
        chk("lit_push_flag", bus.memory_push, 1'b1);
        chk("lit_push_wdata", bus.write_data, 16'h00AB);
        chk("lit_push_regwr", bus.reg_write, 1'b0);
        chk("lit_push_ccr", bus.ccr, 3'b100);

        // Shift edges
        drv(1, 0, 0, 4'd10, 16'h8001, 16'h0001, '0, 0, CTL_RW, 3'd4);
        cycle();
        chk("lit_shl_result", bus.alu_result, 16'h0002);
        chk("lit_shl_ccr", bus.ccr, 3'b100);
        drv(1, 0, 0, 4'd11, 16'h8001, 16'h0000, '0, 0, CTL_RW, 3'd4);
        cycle();
        chk("lit_shr0_result", bus.alu_result, 16'h8001);
        chk("lit_shr0_ccr", bus.ccr, 3'b110);
        drv(1, 0, 0, 4'd13, '0, '0, '0, 0, CTL_NONE, 3'd0);
        cycle();
        drv(1, 0, 0, 4'd11, 16'h8001, 16'h0000, '0, 0, CTL_RW, 3'd4);
        cycle();
        chk("lit_shr0_keeps_c0", bus.ccr, 3'b010);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            drv($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                4'($urandom), rnd_val(), ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 17)) : rnd_val(),
                rnd_val(), $urandom_range(0, 1) == 1, 5'($urandom), RW'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
